muldiv_unit_64: RTL and testbench

MULDIV_UNIT_64 -- requirements
Module: muldiv_unit_64

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/abs_neg_64.sv | 11 +
 rtl/muldiv_unit_64.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit_64.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative 64-bit multiply/divide unit.
// Division support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int WIDTH = 64;
  localparam int ITER  = 64;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_REM   = 3'd5,
    OP_REMU  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/abs_neg_64.sv
// Conditional two's-complement negate, used for operand
// magnitudes and for the final sign fix-up.
module abs_neg_64 (
  input  logic [63:0] val_i,
  input  logic        neg_i,
  output logic [63:0] val_o
);

  assign val_o = neg_i ? (~val_i + 64'd1) : val_i;

endmodule

// File: rtl/muldiv_unit_64.sv
// Iterative 64-bit MUL/MULH/MULHU/DIV/DIVU/REM/REMU unit.
// Define MULDIV_DIV_EN to build the restoring divider.
module muldiv_unit_64
  import muldiv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_result
);

  state_e             state_q;
  op_e                op_q;
  logic               neg_q;
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   bmag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   res_q;

  op_e                op_in;
  logic               sgn_in;
  logic               neg_in;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic               fast;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   fix_in;
  logic [WIDTH-1:0]   fix_out;
  logic [WIDTH-1:0]   final_res;

  assign op_in  = op_e'(i_op);
  assign sgn_in = is_signed_op(op_in);

  abs_neg_64 u_abs_a (
    .val_i (i_a),
    .neg_i (sgn_in & i_a[WIDTH-1]),
    .val_o (amag)
  );

  abs_neg_64 u_abs_b (
    .val_i (i_b),
    .neg_i (sgn_in & i_b[WIDTH-1]),
    .val_o (bmag)
  );

  always_comb begin
    neg_in = 1'b0;
    unique case (op_in)
      OP_MULH, OP_DIV: neg_in = i_a[WIDTH-1] ^ i_b[WIDTH-1];
      OP_REM:          neg_in = i_a[WIDTH-1];
      default:         neg_in = 1'b0;
    endcase
  end

  // Cases resolved at issue without entering BUSY
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    unique case (op_in)
      OP_MUL, OP_MULH, OP_MULHU: fast = 1'b0;
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU: begin
        if (i_b == '0) begin
          fast     = 1'b1;
          fast_res = '1;
        end else if (op_in == OP_DIV &&
                     i_a == {1'b1, {(WIDTH-1){1'b0}}} &&
                     i_b == '1) begin
          fast     = 1'b1;
          fast_res = {1'b1, {(WIDTH-1){1'b0}}};
        end
      end
      OP_REM, OP_REMU: begin
        if (i_b == '0) begin
          fast     = 1'b1;
          fast_res = i_a;
        end else if (op_in == OP_REM &&
                     i_a == {1'b1, {(WIDTH-1){1'b0}}} &&
                     i_b == '1) begin
          fast     = 1'b1;
          fast_res = '0;
        end
      end
`endif
      default: begin
        fast     = 1'b1;
        fast_res = '0;
      end
    endcase
  end

  // Shift-add: multiplier sits in the low half and drains out
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     div_r;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_nxt;
  logic               is_div;

  // Restoring step: {remainder, dividend} shifts left one bit
  assign div_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_r - {1'b0, bmag_q};
  assign div_nxt  = {div_diff[WIDTH] ? div_r[WIDTH-1:0]
                                     : div_diff[WIDTH-1:0],
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
  assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                    (op_q == OP_REM) || (op_q == OP_REMU);
  assign acc_nxt  = is_div ? div_nxt : mul_nxt;
`else
  assign acc_nxt  = mul_nxt;
`endif

  always_comb begin
    fix_in = acc_nxt[2*WIDTH-1:WIDTH];
    unique case (op_q)
      OP_MUL, OP_DIV, OP_DIVU: fix_in = acc_nxt[WIDTH-1:0];
      default:                 fix_in = acc_nxt[2*WIDTH-1:WIDTH];
    endcase
  end

  abs_neg_64 u_fix (
    .val_i (fix_in),
    .neg_i (neg_q),
    .val_o (fix_out)
  );

  // High half of a negated 128-bit product borrows only if low half is 0
  assign final_res = (op_q == OP_MULH && neg_q &&
                      acc_nxt[WIDTH-1:0] != '0)
                   ? ~acc_nxt[2*WIDTH-1:WIDTH]
                   : fix_out;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      bmag_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (i_start) begin
              op_q  <= op_in;
              neg_q <= neg_in;
              cnt_q <= '0;
              if (fast) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                res_q   <= fast_res;
              end else begin
                state_q <= BUSY;
                busy_q  <= 1'b1;
                bmag_q  <= bmag;
                acc_q   <= {{WIDTH{1'b0}}, amag};
              end
            end
          end
          BUSY: begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(ITER - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              res_q   <= final_res;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = res_q;

endmodule

// File: tb/tb_muldiv_unit_64.sv
// Directed self-checking bench for muldiv_unit_64.
// Division vectors are compiled when MULDIV_DIV_EN is defined.
module tb_muldiv_unit_64;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_op;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic        i_flush;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_result;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  muldiv_unit_64 dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] ex);
    checks++;
    assert (obs === ex) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, ex);
    end
  endtask

  // Called just after a falling edge; start is sampled at the next rise (N).
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ex, input int lat);
    int fd = 0;
    int nd = 0;
    int nb = 0;
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        nd++;
        if (fd == 0) fd = k;
      end
      if (o_busy) nb++;
    end
    chk({tag, ".lat"}, 64'(fd), 64'(lat));
    chk({tag, ".ndone"}, 64'(nd), 64'd1);
    chk({tag, ".busy"}, 64'(nb), (lat == 1) ? 64'd0 : 64'd64);
    chk({tag, ".res"}, o_result, ex);
  endtask

  initial begin
    int fd;
    int nd;
    int nb;
    i_rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0;
    i_op = 3'd0; i_a = '0; i_b = '0;
    repeat (2) @(negedge i_clk);
    chk("rst.busy", 64'(o_busy), 64'd0);
    chk("rst.done", 64'(o_done), 64'd0);
    chk("rst.res", o_result, 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op("mul_3x5", 3'd0, 64'd3, 64'd5, 64'd15, 65);
    run_op("mul_m1x7", 3'd0, '1, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 65);
    run_op("mulh_m1m1", 3'd1, '1, '1, 64'd0, 65);
    run_op("mulhu_ffx2", 3'd2, '1, 64'd2, 64'd1, 65);
    run_op("mulh_m3x5", 3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, '1, 65);
    run_op("mulh_minmin", 3'd1, 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65);
    run_op("mulh_minx2", 3'd1, 64'h8000_0000_0000_0000, 64'd2, '1, 65);
    run_op("mulhu_ffff", 3'd2, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("rsvd", 3'd7, 64'd9, 64'd9, 64'd0, 1);

`ifdef MULDIV_DIV_EN
    run_op("div_m7_2", 3'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_m7_2", 3'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
    run_op("divu_100_0", 3'd4, 64'd100, 64'd0, '1, 1);
    run_op("remu_100_0", 3'd6, 64'd100, 64'd0, 64'd100, 1);
    run_op("div_ovf", 3'd3, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 1);
    run_op("divu_100_7", 3'd4, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", 3'd6, 64'd100, 64'd7, 64'd2, 65);
    run_op("div_7_m2", 3'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_7_m2", 3'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
`else
    run_op("mul_pre", 3'd0, 64'd6, 64'd7, 64'd42, 65);
    run_op("divu_off", 3'd4, 64'd10, 64'd2, 64'd0, 1);
    run_op("mul_pre2", 3'd0, 64'd6, 64'd7, 64'd42, 65);
    run_op("rem_off", 3'd5, 64'd10, 64'd3, 64'd0, 1);
`endif

    // start pulses while BUSY and on the DONE->IDLE edge are dropped
    i_op = 3'd0; i_a = 64'd3; i_b = 64'd5; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    fd = 0; nd = 0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        nd++;
        if (fd == 0) fd = k;
      end
      if (k == 10 || k == 65) begin
        i_op = 3'd0; i_a = 64'd2; i_b = 64'd2; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
    end
    chk("ign.lat", 64'(fd), 64'd65);
    chk("ign.ndone", 64'(nd), 64'd1);
    chk("ign.res", o_result, 64'd15);

    // flush mid-operation
    i_op = 3'd0; i_a = 64'd7; i_b = 64'd9; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge i_clk);
      if (o_done) nd++;
      if (k == 21) chk("flush.busy", 64'(o_busy), 64'd0);
      i_flush = (k == 20);
    end
    chk("flush.ndone", 64'(nd), 64'd0);
    chk("flush.res", o_result, 64'd15);

    // flush wins over start
    i_flush = 1'b1; i_start = 1'b1;
    i_op = 3'd0; i_a = 64'd1; i_b = 64'd1;
    @(posedge i_clk); #1 begin i_flush = 1'b0; i_start = 1'b0; end
    nb = 0; nd = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      if (o_busy) nb++;
      if (o_done) nd++;
    end
    chk("prio.busy", 64'(nb), 64'd0);
    chk("prio.done", 64'(nd), 64'd0);

    // asynchronous reset mid-operation
    i_op = 3'd0; i_a = 64'd2; i_b = 64'd3; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    for (int k = 1; k <= 30; k++) @(negedge i_clk);
    chk("arst.pre_busy", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(o_busy), 64'd0);
    chk("arst.done", 64'(o_done), 64'd0);
    chk("arst.res", o_result, 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("mul_after_rst", 3'd0, 64'd2, 64'd2, 64'd4, 65);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
